// File: rtl/r32_prefetch_unit.sv
// Instruction prefetch unit: keeps a small FIFO of fetched words ahead of the
// decoder, with one outstanding memory request and flush-on-redirect.
module r32_prefetch_unit #(
  parameter int                XLEN         = 32,
  parameter int                DEPTH        = 4,
  parameter logic [XLEN-1:0]   RESET_VECTOR = 32'h0000_0000
) (
  input  logic                           i_clock,
  input  logic                           i_reset,
  output logic                           o_mem_req,
  output logic [XLEN-1:0]                o_mem_addr,
  input  logic                           i_mem_ack,
  input  logic [XLEN-1:0]                i_mem_rdata,
  output logic                           o_instr_valid,
  output logic [XLEN-1:0]                o_instr,
  output logic [XLEN-1:0]                o_instr_pc,
  input  logic                           i_instr_ready,
  input  logic                           i_redirect,
  input  logic [XLEN-1:0]                i_redirect_pc,
  output logic [$clog2(DEPTH+1)-1:0]     o_level,
  output logic                           o_error
);

  localparam int LW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              mem_req_q, mem_req_d;
  logic [XLEN-1:0]   mem_addr_q, mem_addr_d;
  logic [XLEN-1:0]   fetch_pc_q, fetch_pc_d;
  logic              error_q;

  logic [XLEN-1:0]   buf_data [DEPTH];
  logic [XLEN-1:0]   buf_pc   [DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [LW-1:0]     count;

  logic              push, pop;
  logic [LW-1:0]     level_after;
  logic [XLEN-1:0]   redirect_tgt;

  assign redirect_tgt = {i_redirect_pc[XLEN-1:2], 2'b00};

  // A redirect wins over both the pop and any arriving data.
  assign pop         = (count != '0) && i_instr_ready && !i_redirect;
  assign push        = (state_q == FETCH) && i_mem_ack && !i_redirect &&
                       ((count < DEPTH_L) || pop);
  assign level_after = count + LW'(push) - LW'(pop);

  always_comb begin
    state_d    = state_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    fetch_pc_d = fetch_pc_q;
    if (i_redirect) begin
      fetch_pc_d = redirect_tgt;
    end
    case (state_q)
      IDLE: begin
        if (i_redirect) begin
          state_d    = FETCH;
          mem_req_d  = 1'b1;
          mem_addr_d = redirect_tgt;
        end else if (count < DEPTH_L) begin
          state_d    = FETCH;
          mem_req_d  = 1'b1;
          mem_addr_d = fetch_pc_q;
        end
      end
      FETCH: begin
        if (i_mem_ack) begin
          if (i_redirect) begin
            mem_addr_d = redirect_tgt;
          end else begin
            fetch_pc_d = fetch_pc_q + XLEN'(4);
            if (level_after < DEPTH_L) begin
              mem_addr_d = fetch_pc_q + XLEN'(4);
            end else begin
              state_d   = IDLE;
              mem_req_d = 1'b0;
            end
          end
        end else if (i_redirect) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        // The stale response is dropped; refetch from the newest target.
        if (i_mem_ack) begin
          state_d    = FETCH;
          mem_req_d  = 1'b1;
          mem_addr_d = i_redirect ? redirect_tgt : fetch_pc_q;
        end
      end
      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q    <= IDLE;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      fetch_pc_q <= RESET_VECTOR;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      fetch_pc_q <= fetch_pc_d;
      if (i_redirect && (i_redirect_pc[1:0] != 2'b00)) begin
        error_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        buf_data[i] <= '0;
        buf_pc[i]   <= '0;
      end
    end else if (i_redirect) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        buf_data[wr_ptr] <= i_mem_rdata;
        buf_pc[wr_ptr]   <= mem_addr_q;
        wr_ptr           <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      count <= level_after;
    end
  end

  assign o_mem_req     = mem_req_q;
  assign o_mem_addr    = mem_addr_q;
  assign o_instr_valid = (count != '0);
  assign o_instr       = buf_data[rd_ptr];
  assign o_instr_pc    = buf_pc[rd_ptr];
  assign o_level       = count;
  assign o_error       = error_q;

endmodule

// File: tb/tb_r32_prefetch_unit.sv
// Scoreboard bench for r32_prefetch_unit: expected PCs are queued by the
// directed tests and a monitor checks every instruction the consumer takes.
module tb_r32_prefetch_unit;

  localparam int XLEN  = 32;
  localparam int DEPTH = 4;

  logic              i_clock = 1'b0;
  logic              i_reset = 1'b1;
  logic              o_mem_req;
  logic [XLEN-1:0]   o_mem_addr;
  logic              i_mem_ack = 1'b0;
  logic [XLEN-1:0]   i_mem_rdata = '0;
  logic              o_instr_valid;
  logic [XLEN-1:0]   o_instr;
  logic [XLEN-1:0]   o_instr_pc;
  logic              i_instr_ready = 1'b0;
  logic              i_redirect = 1'b0;
  logic [XLEN-1:0]   i_redirect_pc = '0;
  logic [2:0]        o_level;
  logic              o_error;

  int                n_checks = 0;
  int                n_fail   = 0;
  logic [31:0]       exp_pc_q [$];
  logic [31:0]       mon_exp;
  bit                resp_en  = 1'b0;
  int                lat      = 1;
  int                wait_cnt = 0;

  r32_prefetch_unit #(
    .XLEN(XLEN), .DEPTH(DEPTH), .RESET_VECTOR(32'h0000_0000)
  ) dut (
    .i_clock(i_clock), .i_reset(i_reset),
    .o_mem_req(o_mem_req), .o_mem_addr(o_mem_addr),
    .i_mem_ack(i_mem_ack), .i_mem_rdata(i_mem_rdata),
    .o_instr_valid(o_instr_valid), .o_instr(o_instr), .o_instr_pc(o_instr_pc),
    .i_instr_ready(i_instr_ready), .i_redirect(i_redirect),
    .i_redirect_pc(i_redirect_pc), .o_level(o_level), .o_error(o_error)
  );

  always #5 i_clock = ~i_clock;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clock);
    #1;
  endtask

  task automatic apply_stimulus_reset();
    i_reset       = 1'b0;
    resp_en       = 1'b0;
    i_mem_ack     = 1'b0;
    i_redirect    = 1'b0;
    i_instr_ready = 1'b0;
    exp_pc_q.delete();
    step();
    step();
    i_reset = 1'b1;
  endtask

  // Acknowledge the current request after lat_cycles edges.
  task automatic apply_stimulus_serve(input int lat_cycles);
    for (int i = 0; i < lat_cycles - 1; i++) step();
    i_mem_ack   = 1'b1;
    i_mem_rdata = mem_word(o_mem_addr);
    step();
    i_mem_ack   = 1'b0;
  endtask

  task automatic wait_drain(input int max_cycles);
    int n;
    n = 0;
    while (exp_pc_q.size() != 0 && n < max_cycles) begin
      step();
      n++;
    end
    check_output("drain_pending", 32'(exp_pc_q.size()), 32'd0);
  endtask

  // Memory model used when resp_en is set: fixed-latency acks.
  always begin
    @(posedge i_clock);
    #1;
    if (resp_en) begin
      if (o_mem_req) begin
        if (wait_cnt >= lat - 1) begin
          i_mem_ack   = 1'b1;
          i_mem_rdata = mem_word(o_mem_addr);
          wait_cnt    = 0;
        end else begin
          i_mem_ack = 1'b0;
          wait_cnt++;
        end
      end else begin
        i_mem_ack = 1'b0;
        wait_cnt  = 0;
      end
    end
  end

  always @(negedge i_clock) begin
    if (i_reset && o_instr_valid && i_instr_ready && !i_redirect) begin
      if (exp_pc_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("[TB] FAIL unexpected_pop: got pc %h expected none", o_instr_pc);
      end else begin
        mon_exp = exp_pc_q.pop_front();
        check_output("pop_pc", o_instr_pc, mon_exp);
        check_output("pop_instr", o_instr, mem_word(mon_exp));
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset values
    #1 i_reset = 1'b0;
    #2;
    check_output("rst_req",   32'(o_mem_req), 32'd0);
    check_output("rst_level", 32'(o_level), 32'd0);
    check_output("rst_valid", 32'(o_instr_valid), 32'd0);
    check_output("rst_error", 32'(o_error), 32'd0);
    check_output("rst_instr", o_instr, 32'd0);
    check_output("rst_pc",    o_instr_pc, 32'd0);
    step();
    step();
    i_reset = 1'b1;
    check_output("req_before_edge", 32'(o_mem_req), 32'd0);
    step();
    check_output("first_req",  32'(o_mem_req), 32'd1);
    check_output("first_addr", o_mem_addr, 32'h0);

    // Back-to-back streaming with single-cycle acks
    for (int i = 0; i < 8; i++) exp_pc_q.push_back(32'(i * 4));
    lat = 1;
    resp_en = 1'b1;
    i_instr_ready = 1'b1;
    wait_drain(40);
    i_instr_ready = 1'b0;
    resp_en = 1'b0;
    i_mem_ack = 1'b0;

    // Fill to DEPTH with no consumer, then one pop frees one slot
    apply_stimulus_reset();
    lat = 1;
    resp_en = 1'b1;
    repeat (10) step();
    check_output("full_level", 32'(o_level), 32'd4);
    check_output("full_req",   32'(o_mem_req), 32'd0);
    check_output("full_head",  o_instr_pc, 32'h0);
    exp_pc_q.push_back(32'h0);
    i_instr_ready = 1'b1;
    step();
    i_instr_ready = 1'b0;
    check_output("after_pop_level", 32'(o_level), 32'd3);
    check_output("after_pop_req",   32'(o_mem_req), 32'd0);
    step();
    check_output("refill_req",  32'(o_mem_req), 32'd1);
    check_output("refill_addr", o_mem_addr, 32'h10);
    step();
    check_output("refill_level", 32'(o_level), 32'd4);
    check_output("refill_idle",  32'(o_mem_req), 32'd0);
    check_output("refill_pops",  32'(exp_pc_q.size()), 32'd0);
    resp_en = 1'b0;
    i_mem_ack = 1'b0;

    // Redirect while a 3-cycle fetch is outstanding
    apply_stimulus_reset();
    i_instr_ready = 1'b1;
    exp_pc_q.push_back(32'h0);
    exp_pc_q.push_back(32'h4);
    exp_pc_q.push_back(32'h100);
    step();
    check_output("t3_addr0", o_mem_addr, 32'h0);
    apply_stimulus_serve(3);
    check_output("t3_addr4", o_mem_addr, 32'h4);
    apply_stimulus_serve(3);
    check_output("t3_addr8", o_mem_addr, 32'h8);
    step();
    i_redirect = 1'b1;
    i_redirect_pc = 32'h100;
    step();
    i_redirect = 1'b0;
    check_output("drain_level", 32'(o_level), 32'd0);
    check_output("drain_req",   32'(o_mem_req), 32'd1);
    check_output("drain_addr",  o_mem_addr, 32'h8);
    i_mem_ack = 1'b1;
    i_mem_rdata = mem_word(32'h8);
    step();
    i_mem_ack = 1'b0;
    check_output("post_drain_addr",  o_mem_addr, 32'h100);
    check_output("post_drain_level", 32'(o_level), 32'd0);
    apply_stimulus_serve(3);
    wait_drain(10);
    i_instr_ready = 1'b0;

    // Redirect coinciding with ack and pop
    apply_stimulus_reset();
    step();
    i_mem_ack = 1'b1;
    i_mem_rdata = mem_word(32'h0);
    step();
    i_mem_ack = 1'b0;
    check_output("t4_level1", 32'(o_level), 32'd1);
    check_output("t4_addr4",  o_mem_addr, 32'h4);
    i_instr_ready = 1'b1;
    i_redirect = 1'b1;
    i_redirect_pc = 32'h200;
    i_mem_ack = 1'b1;
    i_mem_rdata = mem_word(32'h4);
    step();
    i_redirect = 1'b0;
    i_mem_ack = 1'b0;
    i_instr_ready = 1'b0;
    check_output("t4_level0", 32'(o_level), 32'd0);
    check_output("t4_valid",  32'(o_instr_valid), 32'd0);
    check_output("t4_req",    32'(o_mem_req), 32'd1);
    check_output("t4_addr",   o_mem_addr, 32'h200);
    exp_pc_q.push_back(32'h200);
    apply_stimulus_serve(1);
    i_instr_ready = 1'b1;
    wait_drain(10);
    i_instr_ready = 1'b0;

    // Misaligned redirect sets a sticky error
    apply_stimulus_reset();
    i_instr_ready = 1'b1;
    step();
    i_mem_ack = 1'b1;
    i_mem_rdata = mem_word(32'h0);
    i_redirect = 1'b1;
    i_redirect_pc = 32'h102;
    step();
    i_mem_ack = 1'b0;
    i_redirect = 1'b0;
    check_output("mis_error", 32'(o_error), 32'd1);
    check_output("mis_addr",  o_mem_addr, 32'h100);
    check_output("mis_level", 32'(o_level), 32'd0);
    exp_pc_q.push_back(32'h100);
    apply_stimulus_serve(1);
    wait_drain(10);
    i_redirect = 1'b1;
    i_redirect_pc = 32'h300;
    step();
    i_redirect = 1'b0;
    i_instr_ready = 1'b0;
    check_output("mis_sticky", 32'(o_error), 32'd1);
    apply_stimulus_reset();
    check_output("mis_cleared", 32'(o_error), 32'd0);

    // Reset during an outstanding request with a stray ack
    step();
    check_output("t6_req", 32'(o_mem_req), 32'd1);
    step();
    i_reset = 1'b0;
    #1;
    check_output("t6_async_req",   32'(o_mem_req), 32'd0);
    check_output("t6_async_level", 32'(o_level), 32'd0);
    i_mem_ack = 1'b1;
    i_mem_rdata = 32'hBAD0_BAD0;
    step();
    step();
    i_reset = 1'b1;
    step();
    i_mem_ack = 1'b0;
    check_output("t6_req_after",  32'(o_mem_req), 32'd1);
    check_output("t6_addr_after", o_mem_addr, 32'h0);
    check_output("t6_level",      32'(o_level), 32'd0);
    step();
    check_output("t6_level2", 32'(o_level), 32'd0);
    check_output("t6_valid",  32'(o_instr_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
